// File: rtl/ipif_regs_pkg.sv
// Shared types and elaboration helpers for the IPIF register file:
// transaction FSM encoding plus index/width derivation functions.
package ipif_regs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } txn_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Register index width; never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned total);
    return (clog2(total) < 1) ? 1 : clog2(total);
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned dw);
    return clog2(dw / 8);
  endfunction

  // Packed port width for n words; an empty region keeps a single bit
  function automatic int unsigned port_w(input int unsigned n, input int unsigned dw);
    return (n == 0) ? 1 : n * dw;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/ipif_regs_ext_if.sv
// Bus2IP / IP2Bus slave bus bundle between the AXI-Lite IPIF shim and the register file.
interface ipif_regs_ext_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic [AW-1:0]   Bus2IP_Addr;
  logic            Bus2IP_CS;
  logic            Bus2IP_RNW;
  logic [DW-1:0]   Bus2IP_Data;
  logic [DW/8-1:0] Bus2IP_BE;
  logic [DW-1:0]   IP2Bus_Data;
  logic            IP2Bus_RdAck;
  logic            IP2Bus_WrAck;
  logic            IP2Bus_Error;

  modport master (
    output Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/ipif_txn_fsm.sv
// Transaction sequencer: one registered ack (and error) per CS assertion,
// plus a combinational start strobe for the register file update.
module ipif_txn_fsm
  import ipif_regs_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cs_i,
  input  logic rnw_i,
  input  logic illegal_i,
  output logic start_c_o,
  output logic rd_ack_o,
  output logic wr_ack_o,
  output logic err_o
);

  txn_state_e state_q, state_d;
  logic       rd_ack_q, rd_ack_d;
  logic       wr_ack_q, wr_ack_d;
  logic       err_q, err_d;
  logic       start_c;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
      err_q    <= err_d;
    end
  end

  // HOLD absorbs a long CS so the ack fires only once per assertion
  always_comb begin
    state_d  = state_q;
    rd_ack_d = 1'b0;
    wr_ack_d = 1'b0;
    err_d    = 1'b0;
    start_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_i) begin
          state_d  = ST_ACK;
          start_c  = 1'b1;
          rd_ack_d = rnw_i;
          wr_ack_d = !rnw_i;
          err_d    = illegal_i;
        end
      end
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: if (!cs_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign start_c_o = start_c;
  assign rd_ack_o  = rd_ack_q;
  assign wr_ack_o  = wr_ack_q;
  assign err_o     = err_q;

endmodule

// File: rtl/ipif_regs_ext.sv
// IPIF register file: WO, RW and RO regions with byte enables, error acks and access strobes.
// Define IPIF_REGS_RO_SNAPSHOT_EN for coherent multi-word RO reads via a snapshot bank.
module ipif_regs_ext
  import ipif_regs_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_WO_REGS        = 1,
  parameter int unsigned NUM_RW_REGS        = 1,
  parameter int unsigned NUM_RO_REGS        = 1,
  parameter logic [port_w(NUM_WO_REGS + NUM_RW_REGS, C_S_AXI_DATA_WIDTH)-1:0] RESET_VALUES = '0
) (
  input  logic Bus2IP_Clk,
  input  logic Bus2IP_Resetn,
  ipif_regs_ext_if.slave bus,
  output logic [port_w(NUM_WO_REGS, C_S_AXI_DATA_WIDTH)-1:0] wo_regs,
  output logic [port_w(NUM_RW_REGS, C_S_AXI_DATA_WIDTH)-1:0] rw_regs,
  input  logic [port_w(NUM_RO_REGS, C_S_AXI_DATA_WIDTH)-1:0] ro_regs,
  output logic [cnt_w(NUM_WO_REGS + NUM_RW_REGS)-1:0]        wr_pulse,
  output logic [cnt_w(NUM_RW_REGS + NUM_RO_REGS)-1:0]        rd_pulse
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB       = DW / 8;
  localparam int unsigned NWR      = NUM_WO_REGS + NUM_RW_REGS;
  localparam int unsigned TOTAL    = NWR + NUM_RO_REGS;
  localparam int unsigned IDX_W    = idx_w(TOTAL);
  localparam int unsigned ADDR_LSB = addr_lsb(DW);
  localparam int unsigned NREG_S   = cnt_w(NWR);
  localparam int unsigned NWP      = cnt_w(NWR);
  localparam int unsigned NRP      = cnt_w(NUM_RW_REGS + NUM_RO_REGS);

  logic [IDX_W-1:0] idx;
  logic [31:0]      idx_u;
  logic             wr_legal, rd_legal, illegal;
  logic             start_c, do_wr, do_rd;

  logic [DW-1:0]  regs_q [NREG_S];
  logic [DW-1:0]  regs_d [NREG_S];
  logic [NWP-1:0] wr_pulse_q, wr_pulse_d;
  logic [NRP-1:0] rd_pulse_q, rd_pulse_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  // Only the index field of the byte address is decoded
  assign idx      = bus.Bus2IP_Addr[ADDR_LSB +: IDX_W];
  assign idx_u    = 32'(idx);
  assign wr_legal = (idx_u < NWR);
  assign rd_legal = (idx_u >= NUM_WO_REGS) && (idx_u < TOTAL);
  assign illegal  = bus.Bus2IP_RNW ? !rd_legal : !wr_legal;
  assign do_wr    = start_c && !bus.Bus2IP_RNW && wr_legal;
  assign do_rd    = start_c && bus.Bus2IP_RNW && rd_legal;

  ipif_txn_fsm u_txn_fsm (
    .clk_i     (Bus2IP_Clk),
    .rst_ni    (Bus2IP_Resetn),
    .cs_i      (bus.Bus2IP_CS),
    .rnw_i     (bus.Bus2IP_RNW),
    .illegal_i (illegal),
    .start_c_o (start_c),
    .rd_ack_o  (bus.IP2Bus_RdAck),
    .wr_ack_o  (bus.IP2Bus_WrAck),
    .err_o     (bus.IP2Bus_Error)
  );

  // Byte-enabled write into the WO/RW bank
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    for (int unsigned r = 0; r < NWR; r++) begin
      if (do_wr && (idx_u == r)) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (bus.Bus2IP_BE[b]) regs_d[r][8*b +: 8] = bus.Bus2IP_Data[8*b +: 8];
        end
        wr_pulse_d[r] = |bus.Bus2IP_BE;
      end
    end
  end

`ifdef IPIF_REGS_RO_SNAPSHOT_EN
  localparam int unsigned NRO_S = cnt_w(NUM_RO_REGS);
  logic [DW-1:0] snap_q [NRO_S];
  logic [DW-1:0] snap_d [NRO_S];
`endif

  // Read mux and read strobes; data is forced to zero outside a legal read ack
  always_comb begin
    rdata_d    = '0;
    rd_pulse_d = '0;
`ifdef IPIF_REGS_RO_SNAPSHOT_EN
    snap_d     = snap_q;
`endif
    for (int unsigned r = NUM_WO_REGS; r < NWR; r++) begin
      if (do_rd && (idx_u == r)) begin
        rdata_d                      = regs_q[r];
        rd_pulse_d[r - NUM_WO_REGS] = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_RO_REGS; k++) begin
      if (do_rd && (idx_u == NWR + k)) begin
`ifdef IPIF_REGS_RO_SNAPSHOT_EN
        rdata_d = (k == 0) ? ro_regs[k*DW +: DW] : snap_q[k];
`else
        rdata_d = ro_regs[k*DW +: DW];
`endif
        rd_pulse_d[NUM_RW_REGS + k] = 1'b1;
      end
    end
`ifdef IPIF_REGS_RO_SNAPSHOT_EN
    // Reading RO0 freezes the remaining RO words for a coherent follow-up read
    if (do_rd && (idx_u == NWR)) begin
      for (int unsigned k = 1; k < NUM_RO_REGS; k++) snap_d[k] = ro_regs[k*DW +: DW];
    end
`endif
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      regs_q <= '{default: '0};
      for (int unsigned r = 0; r < NWR; r++) regs_q[r] <= RESET_VALUES[r*DW +: DW];
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      rdata_q    <= '0;
`ifdef IPIF_REGS_RO_SNAPSHOT_EN
      snap_q     <= '{default: '0};
`endif
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      rdata_q    <= rdata_d;
`ifdef IPIF_REGS_RO_SNAPSHOT_EN
      snap_q     <= snap_d;
`endif
    end
  end

  assign bus.IP2Bus_Data = rdata_q;
  assign wr_pulse        = wr_pulse_q;
  assign rd_pulse        = rd_pulse_q;

  generate
    if (NUM_WO_REGS > 0) begin : g_wo
      for (genvar g = 0; g < NUM_WO_REGS; g++) begin : g_w
        assign wo_regs[g*DW +: DW] = regs_q[g];
      end
    end else begin : g_wo_none
      assign wo_regs = '0;
    end
    if (NUM_RW_REGS > 0) begin : g_rw
      for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_r
        assign rw_regs[g*DW +: DW] = regs_q[NUM_WO_REGS + g];
      end
    end else begin : g_rw_none
      assign rw_regs = '0;
    end
  endgenerate

  // Address bits above the index field and empty-region inputs are intentionally ignored
  logic unused_inputs;
  assign unused_inputs = ^{bus.Bus2IP_Addr, ro_regs};

endmodule

// File: tb/tb_ipif_regs_ext.sv
// Scoreboard bench for ipif_regs_ext: expected acks/data/strobes queued at CS, checked at each ack.
module tb_ipif_regs_ext;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned NWO = 1;
  localparam int unsigned NRW = 1;
  localparam int unsigned NRO = 3;
  localparam logic [63:0] RST_VALS = {32'hA5A5_A5A5, 32'h0000_0001};

  typedef struct {
    logic        rnw;
    logic        err;
    logic [31:0] data;
    logic [1:0]  wp;
    logic [3:0]  rp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ipif_regs_ext_if #(.DW(DW), .AW(AW)) bus ();

  logic [31:0] wo_regs, rw_regs;
  logic [95:0] ro_regs;
  logic [95:0] ro_set;
  logic        ro_spin;
  logic [1:0]  wr_pulse;
  logic [3:0]  rd_pulse;

  ipif_regs_ext #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .NUM_WO_REGS        (NWO),
    .NUM_RW_REGS        (NRW),
    .NUM_RO_REGS        (NRO),
    .RESET_VALUES       (RST_VALS)
  ) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .bus           (bus),
    .wo_regs       (wo_regs),
    .rw_regs       (rw_regs),
    .ro_regs       (ro_regs),
    .wr_pulse      (wr_pulse),
    .rd_pulse      (rd_pulse)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned ack_cnt = 0;
  logic        mon_en  = 1'b0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  exp_t        drv_e;
  logic [31:0] m_regs [2];
  logic [31:0] m_snap [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RO inputs only change just after a rising edge, so the bench reads stable values at negedge
  always @(posedge clk) begin
    #2;
    if (ro_spin) ro_regs = {$urandom, $urandom, $urandom};
    else         ro_regs = ro_set;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.IP2Bus_RdAck || bus.IP2Bus_WrAck) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_ack", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("rdack",    64'(bus.IP2Bus_RdAck), 64'(mon_e.rnw));
          check("wrack",    64'(bus.IP2Bus_WrAck), 64'(!mon_e.rnw));
          check("error",    64'(bus.IP2Bus_Error), 64'(mon_e.err));
          check("rdata",    64'(bus.IP2Bus_Data),  64'(mon_e.data));
          check("wr_pulse", 64'(wr_pulse),         64'(mon_e.wp));
          check("rd_pulse", 64'(rd_pulse),         64'(mon_e.rp));
        end
      end else begin
        check("idle_data", 64'(bus.IP2Bus_Data),  64'd0);
        check("idle_err",  64'(bus.IP2Bus_Error), 64'd0);
        check("idle_wp",   64'(wr_pulse),         64'd0);
        check("idle_rp",   64'(rd_pulse),         64'd0);
      end
    end
  end

  function automatic exp_t build_exp(input logic rnw, input int unsigned idx,
                                     input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    logic wr_ok, rd_ok;
    int unsigned k;
    wr_ok  = (idx < 2);
    rd_ok  = (idx >= 1) && (idx < 5);
    e.rnw  = rnw;
    e.err  = rnw ? !rd_ok : !wr_ok;
    e.data = '0;
    e.wp   = '0;
    e.rp   = '0;
    if (!rnw && wr_ok) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_regs[idx][8*b +: 8] = wdata[8*b +: 8];
      if (be != 4'd0) e.wp[idx] = 1'b1;
    end
    if (rnw && rd_ok) begin
      e.rp[idx-1] = 1'b1;
      if (idx == 1) begin
        e.data = m_regs[1];
      end else begin
        k = idx - 2;
`ifdef IPIF_REGS_RO_SNAPSHOT_EN
        if (k == 0) begin
          e.data    = ro_regs[31:0];
          m_snap[1] = ro_regs[63:32];
          m_snap[2] = ro_regs[95:64];
        end else begin
          e.data = m_snap[k];
        end
`else
        e.data = ro_regs[k*32 +: 32];
`endif
      end
    end
    return e;
  endfunction

  task automatic txn(input logic rnw, input int unsigned idx, input logic [31:0] wdata,
                     input logic [3:0] be, input int unsigned hold);
    int unsigned a0;
    @(negedge clk);
    exp_q.push_back(build_exp(rnw, idx, wdata, be));
    bus.Bus2IP_Addr = 32'(idx) << 2;
    bus.Bus2IP_RNW  = rnw;
    bus.Bus2IP_Data = wdata;
    bus.Bus2IP_BE   = be;
    bus.Bus2IP_CS   = 1'b1;
    a0 = ack_cnt;
    @(negedge clk);
    check("ack_latency", 64'(rnw ? bus.IP2Bus_RdAck : bus.IP2Bus_WrAck), 64'd1);
    repeat (hold - 1) @(negedge clk);
    bus.Bus2IP_CS = 1'b0;
    repeat (2) @(negedge clk);
    check("ack_count", 64'(ack_cnt - a0), 64'd1);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_wo"}, 64'(wo_regs), 64'(m_regs[0]));
    check({tag, "_rw"}, 64'(rw_regs), 64'(m_regs[1]));
  endtask

  task automatic model_reset();
    m_regs[0] = RST_VALS[31:0];
    m_regs[1] = RST_VALS[63:32];
    for (int i = 0; i < 3; i++) m_snap[i] = '0;
  endtask

  initial begin
    bus.Bus2IP_Addr = '0;
    bus.Bus2IP_CS   = 1'b0;
    bus.Bus2IP_RNW  = 1'b0;
    bus.Bus2IP_Data = '0;
    bus.Bus2IP_BE   = '0;
    ro_spin = 1'b0;
    ro_set  = {32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A};
    ro_regs = ro_set;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_wo",    64'(wo_regs), 64'h0000_0001);
    check("rst_rw",    64'(rw_regs), 64'hA5A5_A5A5);
    check("rst_rdack", 64'(bus.IP2Bus_RdAck), 64'd0);
    check("rst_wrack", 64'(bus.IP2Bus_WrAck), 64'd0);
    check("rst_err",   64'(bus.IP2Bus_Error), 64'd0);
    check("rst_data",  64'(bus.IP2Bus_Data),  64'd0);
    check("rst_wp",    64'(wr_pulse), 64'd0);
    check("rst_rp",    64'(rd_pulse), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    txn(1'b0, 1, 32'hDEAD_BEEF, 4'hF, 6);
    check_regs("wr_full");
    txn(1'b0, 1, 32'h1234_5678, 4'h3, 2);
    check("rw_be3", 64'(rw_regs), 64'hDEAD_5678);
    txn(1'b0, 1, 32'hFFFF_FFFF, 4'h0, 1);
    check_regs("wr_be0");
    txn(1'b0, 0, 32'hCAFE_F00D, 4'hC, 3);
    check("wo_bec", 64'(wo_regs), 64'hCAFE_0001);
    txn(1'b1, 1, 32'h0, 4'h0, 1);

    txn(1'b1, 0, 32'h0, 4'h0, 2);
    txn(1'b0, 3, 32'h7777_7777, 4'hF, 1);
    check_regs("wr_ro");
    txn(1'b1, 5, 32'h0, 4'h0, 1);
    txn(1'b0, 5, 32'h9999_9999, 4'hF, 1);
    check_regs("wr_oob");

    ro_spin = 1'b1;
    txn(1'b1, 4, 32'h0, 4'h0, 3);
    txn(1'b1, 3, 32'h0, 4'h0, 1);
    ro_spin = 1'b0;

    ro_set = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    @(negedge clk);
    txn(1'b1, 2, 32'h0, 4'h0, 1);
    ro_set = {32'h6666_6666, 32'h5555_5555, 32'h4444_4444};
    @(negedge clk);
    txn(1'b1, 3, 32'h0, 4'h0, 1);
    txn(1'b1, 4, 32'h0, 4'h0, 1);
    txn(1'b1, 2, 32'h0, 4'h0, 1);

    // Reset lands in the ACK cycle of a write
    @(negedge clk);
    drv_e = build_exp(1'b0, 1, 32'h55AA_55AA, 4'hF);
    exp_q.push_back(drv_e);
    bus.Bus2IP_Addr = 32'd1 << 2;
    bus.Bus2IP_RNW  = 1'b0;
    bus.Bus2IP_Data = 32'h55AA_55AA;
    bus.Bus2IP_BE   = 4'hF;
    bus.Bus2IP_CS   = 1'b1;
    @(negedge clk);
    check("mid_ack", 64'(bus.IP2Bus_WrAck), 64'd1);
    check("mid_rw",  64'(rw_regs), 64'h55AA_55AA);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check("mid_rst_wo",    64'(wo_regs), 64'h0000_0001);
    check("mid_rst_rw",    64'(rw_regs), 64'hA5A5_A5A5);
    check("mid_rst_wrack", 64'(bus.IP2Bus_WrAck), 64'd0);
    bus.Bus2IP_CS = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 1, 32'h0BAD_F00D, 4'hF, 2);
    check_regs("post_rst");
    txn(1'b1, 1, 32'h0, 4'h0, 1);

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ipif_regs_ext.md
Name: ipif_regs_ext

Overview:
Parametrised IPIF register file: software-writable, hardware-readable and hardware-written registers behind the Bus2IP/IP2Bus slave interface. It extends the basic WO/RW/RO register block with:
- byte-enable writes and per-register reset values
- one-shot ack per transaction via a transaction FSM
- error response on illegal accesses
- per-register access strobes to hardware
It sits between the AXI-Lite IPIF shim and a datapath core's control/status logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; multiple of 8.
C_S_AXI_ADDR_WIDTH, 32, bus address width.
NUM_WO_REGS, 1, SW-write / HW-read registers; occupy indices 0..NUM_WO_REGS-1.
NUM_RW_REGS, 1, SW-write / SW+HW-read registers; occupy the next NUM_RW_REGS indices.
NUM_RO_REGS, 1, HW-write / SW-read registers; occupy the last NUM_RO_REGS indices.
RESET_VALUES, all zeros, packed reset values for the WO then RW registers; width (NUM_WO_REGS+NUM_RW_REGS)*C_S_AXI_DATA_WIDTH.

Ports:
Bus2IP_Clk  in  1  clock.
Bus2IP_Resetn  in  1  reset; synchronous, active-low.
Bus2IP_Addr  in  C_S_AXI_ADDR_WIDTH  byte address.
Bus2IP_CS  in  1  block select; held high until ack.
Bus2IP_RNW  in  1  1=read, 0=write.
Bus2IP_Data  in  C_S_AXI_DATA_WIDTH  write data.
Bus2IP_BE  in  C_S_AXI_DATA_WIDTH/8  byte enables.
IP2Bus_Data  out  C_S_AXI_DATA_WIDTH  read data.
IP2Bus_RdAck  out  1  read ack, 1-cycle pulse.
IP2Bus_WrAck  out  1  write ack, 1-cycle pulse.
IP2Bus_Error  out  1  error, coincident with ack.
wo_regs  out  NUM_WO_REGS*C_S_AXI_DATA_WIDTH  packed WO registers.
rw_regs  out  NUM_RW_REGS*C_S_AXI_DATA_WIDTH  packed RW registers.
ro_regs  in  NUM_RO_REGS*C_S_AXI_DATA_WIDTH  packed RO inputs.
wr_pulse  out  NUM_WO_REGS+NUM_RW_REGS  per-register write strobe.
rd_pulse  out  NUM_RW_REGS+NUM_RO_REGS  per-register read strobe.

Behaviour:
- Reset: single clock Bus2IP_Clk; Bus2IP_Resetn is synchronous, active-low. While it is low, every output is reset: WO/RW registers take RESET_VALUES; acks, Error, wr_pulse, rd_pulse = 0; IP2Bus_Data = 0; FSM = IDLE.
- Decode: TOTAL = NUM_WO_REGS+NUM_RW_REGS+NUM_RO_REGS. IDX_W = clog2(TOTAL), minimum 1. ADDR_LSB = clog2(C_S_AXI_DATA_WIDTH/8). Index = Bus2IP_Addr[ADDR_LSB+IDX_W-1:ADDR_LSB]; higher address bits are ignored.
- FSM states:
  - IDLE: CS=1 → ACK.
  - ACK: lasts one cycle; drives the ack (plus Error if illegal) and any strobe; → HOLD.
  - HOLD: stays while CS=1; CS=0 → IDLE.
  Exactly one ack per CS assertion, however long CS is held.
- Latency: CS sampled in cycle N; ack, register update and strobe all appear in N+1.
- Legal write (index < NUM_WO_REGS+NUM_RW_REGS): byte b updated iff BE[b]=1. wr_pulse[index]=1 in the ack cycle iff BE≠0. BE=0 → ack with no change and no strobe.
- Legal read (index ≥ NUM_WO_REGS and index < TOTAL): IP2Bus_Data = RW register, or the ro_regs slice as sampled in cycle N. rd_pulse[index-NUM_WO_REGS]=1 in the ack cycle.
- IP2Bus_Data = 0 whenever RdAck=0.
- Illegal access (read of WO, write of RO, index ≥ TOTAL): normal ack with Error=1; no register change, no strobe, read data 0.
- Any parameter set to 0 must elaborate: that region is empty, and its port is width-1 and unused.
- Reset mid-transaction (in ACK or HOLD): next cycle all outputs take reset values and FSM = IDLE. If CS is still high after release, it is treated as a new transaction.

Optional Feature:
Macro IPIF_REGS_RO_SNAPSHOT_EN.
- Defined: a read of the first RO index returns its live value and, in the same cycle, latches all other RO inputs into a snapshot bank. Reads of the other RO indices return the snapshot, so multi-word counters read coherently. The snapshot resets to 0.
- Undefined: all RO reads return live values and no snapshot storage exists.

Decomposition:
- Package ipif_regs_pkg: clog2 function, FSM state encoding (IDLE/ACK/HOLD), ADDR_LSB/IDX_W derivation.
- One sub-module, ipif_txn_fsm: CS/RNW sampling, the three-state FSM, ack/error generation. The register file and decode stay in the top module.

Test Plan:
- Reset with RESET_VALUES = {0xA5A5A5A5, 0x00000001}: wo_regs/rw_regs match; acks, Error, strobes and IP2Bus_Data are 0.
- Write 0xDEADBEEF, BE=0xF, to the RW index with CS held 6 cycles: exactly one WrAck one cycle after CS, the register = 0xDEADBEEF, one wr_pulse.
- Then write 0x12345678, BE=0x3, to the same register: it becomes 0xDEAD5678. Repeat with BE=0x0: ack, register unchanged, no pulse.
- Read WO index 0: RdAck+Error, data 0. Write an RO index: WrAck+Error, no strobe. Access index TOTAL: Error ack.
- Read RO index while ro_regs changes every cycle: data equals the value sampled at the CS cycle, with one rd_pulse. With the macro, read RO0 then change ro_regs then read RO1: RO1 returns the value latched at the RO0 read.
- Assert reset in the ACK cycle of a write: next cycle registers = RESET_VALUES, acks 0. Release reset with CS low: the next transaction acks normally.
